// File: rtl/datapath_run_controller.sv
// datapath_run_controller: sequences one datapath run. The core is held in
// reset for RESET_CYCLES cycles, then enabled until it halts or the
// RUN_CYCLES budget is used up.
// Optional build macro: DPRC_SINGLE_STEP_EN. It adds the Step port, and in
// RUN the core is enabled for one cycle per rising edge of Step.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | core held in reset, waiting for Start
// S_RESET | core held in reset for RESET_CYCLES cycles
// S_RUN   | core released and clock-enabled, enabled cycles counted
// S_DONE  | core frozen (out of reset, not enabled), result reported
module datapath_run_controller #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned RUN_CYCLES   = 15,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic                 Halt,
`ifdef DPRC_SINGLE_STEP_EN
  input  logic                 Step,
`endif
  output logic                 CoreRst,
  output logic                 CoreEn,
  output logic                 Busy,
  output logic                 Done,
  output logic                 TimedOut,
  output logic [CNT_WIDTH-1:0] CycleCount
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0]        RST_LAST = RW'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_MAX  = CNT_WIDTH'(RUN_CYCLES);
  localparam logic [CNT_WIDTH-1:0] RUN_PEN  = CNT_WIDTH'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t               state, state_d;
  logic [RW-1:0]        rst_cnt, rst_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 to_d;
  logic                 en_req;

`ifdef DPRC_SINGLE_STEP_EN
  logic step_q;

  // Step history for rising-edge detection.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) step_q <= 1'b0;
    else     step_q <= Step;
  end

  assign en_req = Step & ~step_q;
`else
  assign en_req = 1'b1;
`endif

  // Next-state, counter and result logic; Abort overrides everything.
  always_comb begin
    state_d   = state;
    rst_cnt_d = rst_cnt;
    cnt_d     = CycleCount;
    to_d      = TimedOut;
    if (Abort) begin
      state_d = S_IDLE;
      to_d    = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
            cnt_d     = '0;
            to_d      = 1'b0;
          end
        end
        S_RESET: begin
          if (rst_cnt == RST_LAST) state_d = S_RUN;
          else                     rst_cnt_d = rst_cnt + RW'(1);
        end
        S_RUN: begin
          // Only enabled cycles count or see Halt. A halt that lands on the
          // budget-reaching cycle still reports the full count, but as a halt.
          if (CoreEn) begin
            if (Halt) begin
              state_d = S_DONE;
              to_d    = 1'b0;
              if (CycleCount == RUN_PEN) cnt_d = RUN_MAX;
            end else begin
              cnt_d = CycleCount + CNT_WIDTH'(1);
              if (CycleCount == RUN_PEN) begin
                state_d = S_DONE;
                to_d    = 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      rst_cnt    <= '0;
      CycleCount <= '0;
      TimedOut   <= 1'b0;
      CoreRst    <= 1'b1;
      CoreEn     <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= state_d;
      rst_cnt    <= rst_cnt_d;
      CycleCount <= cnt_d;
      TimedOut   <= to_d;
      CoreRst    <= (state_d == S_IDLE) || (state_d == S_RESET);
      CoreEn     <= (state_d == S_RUN) && en_req;
      Busy       <= (state_d == S_RESET) || (state_d == S_RUN);
      Done       <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_datapath_run_controller.sv
// Self-checking bench for datapath_run_controller: a vector table, directed
// corner-case sequences and random stimulus checked against a run-level model.
module tb_datapath_run_controller;

  localparam int RC = 2;
  localparam int RN = 15;
  localparam int CW = 16;

  localparam int P_IDLE  = 0;
  localparam int P_RESET = 1;
  localparam int P_RUN   = 2;
  localparam int P_DONE  = 3;

  logic          Clk_tb = 1'b0;
  logic          rst, start, abort, halt, step;
  logic          core_rst, core_en, busy, done, timed_out;
  logic [CW-1:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what phase the run is in and what it has accumulated.
  int m_phase, m_rst_left, m_count;
  bit m_to, m_en, m_step_prev;

  always #5 Clk_tb = ~Clk_tb;

  datapath_run_controller #(.RESET_CYCLES(RC), .RUN_CYCLES(RN), .CNT_WIDTH(CW)) dut (
    .Clk(Clk_tb),
    .Rst(rst),
    .Start(start),
    .Abort(abort),
    .Halt(halt),
`ifdef DPRC_SINGLE_STEP_EN
    .Step(step),
`endif
    .CoreRst(core_rst),
    .CoreEn(core_en),
    .Busy(busy),
    .Done(done),
    .TimedOut(timed_out),
    .CycleCount(cycle_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_rst_left = 0; m_count = 0;
    m_to = 0; m_en = 0; m_step_prev = 0;
  endtask

  // One rising edge of the run sequence, from the inputs applied before it.
  task automatic model_edge();
    bit rise;
    rise = step && !m_step_prev;
    m_step_prev = step;
    if (abort) begin
      m_phase = P_IDLE;
      m_to = 0;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE:
          if (start) begin
            m_phase = P_RESET; m_rst_left = RC; m_count = 0; m_to = 0;
          end
        P_RESET: begin
          m_rst_left--;
          if (m_rst_left == 0) m_phase = P_RUN;
        end
        default:
          if (m_en) begin
            if (halt) begin
              m_phase = P_DONE; m_to = 0;
              if (m_count == RN - 1) m_count = RN;
            end else begin
              m_count++;
              if (m_count == RN) begin m_phase = P_DONE; m_to = 1; end
            end
          end
      endcase
    end
`ifdef DPRC_SINGLE_STEP_EN
    m_en = (m_phase == P_RUN) && rise;
`else
    m_en = (m_phase == P_RUN);
`endif
  endtask

  task automatic check_model();
    chk("m_core_rst", core_rst, int'(m_phase == P_IDLE || m_phase == P_RESET));
    chk("m_core_en", core_en, int'(m_en));
    chk("m_busy", busy, int'(m_phase == P_RESET || m_phase == P_RUN));
    chk("m_done", done, int'(m_phase == P_DONE));
    chk("m_cycle_count", cycle_count, m_count);
    if (m_phase == P_IDLE || m_phase == P_DONE) chk("m_timed_out", timed_out, int'(m_to));
  endtask

  task automatic cyc(input bit s, input bit a, input bit h, input bit st);
    start = s; abort = a; halt = h; step = st;
    @(posedge Clk_tb);
    model_edge();
    @(negedge Clk_tb);
    check_model();
  endtask

  // Start a run and raise Halt during enabled cycle number 'at'.
  task automatic run_with_halt(input int at, input int exp_cnt, input string tag);
    int k;
    bit seen, h;
    k = 0; seen = 0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (core_en) k++;
      h = core_en && (k == at);
      cyc(0, 0, h, 0);
      if (h) seen = 1;
    end
    chk({tag, "_reached"}, int'(seen), 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_count"}, cycle_count, exp_cnt);
    chk({tag, "_en_off"}, core_en, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk({tag, "_en_frozen"}, core_en, 0);
    chk({tag, "_count_hold"}, cycle_count, exp_cnt);
  endtask

  typedef struct {
    bit s, a, h;
    bit e_rst, e_en, e_busy, e_done, e_to;
    int e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int rcyc, ecyc;
    bit fin;

    rst = 1; start = 0; abort = 0; halt = 0; step = 0;
    model_reset();
    repeat (2) @(negedge Clk_tb);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_en", core_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_count", cycle_count, 0);
    rst = 0;

`ifndef DPRC_SINGLE_STEP_EN
    // Start, reset phase, four run cycles, abort at count 4, idle hold.
    tbl[0] = '{1, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 1, 0, 1, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
    tbl[4] = '{1, 0, 0, 0, 1, 1, 0, 0, 2};
    tbl[5] = '{0, 0, 0, 0, 1, 1, 0, 0, 3};
    tbl[6] = '{0, 0, 0, 0, 1, 1, 0, 0, 4};
    tbl[7] = '{0, 1, 0, 1, 0, 0, 0, 0, 4};
    tbl[8] = '{0, 0, 0, 1, 0, 0, 0, 0, 4};
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].s, tbl[i].a, tbl[i].h, 0);
      chk($sformatf("tbl%0d_core_rst", i), core_rst, int'(tbl[i].e_rst));
      chk($sformatf("tbl%0d_core_en", i), core_en, int'(tbl[i].e_en));
      chk($sformatf("tbl%0d_busy", i), busy, int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), done, int'(tbl[i].e_done));
      chk($sformatf("tbl%0d_timed_out", i), timed_out, int'(tbl[i].e_to));
      chk($sformatf("tbl%0d_count", i), cycle_count, tbl[i].e_cnt);
    end

    // Restart after abort: count clears, then a full-budget run.
    cyc(1, 0, 0, 0);
    chk("restart_count_clear", cycle_count, 0);
    rcyc = (core_rst && busy) ? 1 : 0;
    ecyc = 0;
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      cyc(0, 0, 0, 0);
      if (core_rst && busy) rcyc++;
      if (core_en) ecyc++;
      if (done) fin = 1;
    end
    chk("full_reached_done", int'(fin), 1);
    chk("full_reset_cycles", rcyc, RC);
    chk("full_en_cycles", ecyc, RN);
    chk("full_timed_out", timed_out, 1);
    chk("full_count", cycle_count, RN);

    run_with_halt(7, 6, "halt7");
    run_with_halt(15, 15, "halt15");

    // Asynchronous reset between edges while running.
    cyc(1, 0, 0, 0);
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      cyc(0, 0, 0, 0);
      if (cycle_count == 3) fin = 1;
    end
    chk("arst_reached_run", int'(fin), 1);
    #2 rst = 1;
    #1;
    chk("arst_core_rst", core_rst, 1);
    chk("arst_core_en", core_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", cycle_count, 0);
    #1 rst = 0;
    model_reset();
`else
    // Three Step rising edges in RUN, one of them held five cycles.
    begin
      bit pat[14];
      int pulses;
      pat = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("step_in_run", busy && !core_rst, 1);
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
        cyc(0, 0, 0, pat[i]);
        if (core_en) pulses++;
      end
      chk("step_pulses", pulses, 3);
      chk("step_count", cycle_count, 3);
      cyc(0, 1, 0, 0);
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
